mem_seq: RTL

- Memory-access sequencer that sits directly upstream of the data MEMORY block (AR register plus synchronous RAM).
- Turns one instruction-level request into the cycle-exact control strobes MEMORY needs: ADDR, srcA, wAR and wM, plus the register-R load strobe wR.
- Request types are READ (COPYFROM/ADD/SUB operand), WRITE (COPYTO) and RMW (BUMPUP/BUMPDN); each may be direct or indirect.
- The control unit issues a request with start and waits for done.

---
 rtl/mem_seq_pkg.sv | 22 ++
 rtl/mem_seq_lat.sv | 29 ++
 rtl/mem_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory-access sequencer: request opcodes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_seq_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RMW   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETA  = 3'd1,
        WAITP = 3'd2,
        SETI  = 3'd3,
        WAITD = 3'd4,
        LOADR = 3'd5,
        WRM   = 3'd6,
        NOP   = 3'd7
    } state_t;

endpackage

// File: rtl/mem_seq_lat.sv
// Loadable down-counter with zero flag that times the RAM read-latency wait states.
// Latency: load and decrement take effect at the next clk edge; zero is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module lat_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_seq.sv
// Sequences one READ/WRITE/RMW request (direct or indirect) into MEMORY strobes ADDR/srcA/wAR/wM and R load wR.
// Latency: start edge to done is 3/5 READ, 2/4 WRITE, 4/6 RMW, 1 reserved (RD_LAT=1); +RD_LAT-1 per wait state.
// Backpressure: start is sampled only in IDLE; requests arriving while busy are dropped, not queued.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              ind,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ADDR,
    output logic              srcA,
    output logic              wAR,
    output logic              wM,
    output logic              wR
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

    state_t            state;
    state_t            state_n;
    logic [1:0]        op_q;
    logic              ind_q;
    logic              wait_zero;
    logic              wait_load;
    logic              wait_dec;
    logic              accept;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request context only moves on an accepted start, so a start while busy cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ADDR  <= '0;
            op_q  <= OP_READ;
            ind_q <= 1'b0;
        end else if (accept) begin
            ADDR  <= addr;
            op_q  <= op;
            ind_q <= ind;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (op == OP_RSVD) ? NOP : SETA;
                end
            end
            SETA: begin
                if (ind_q) begin
                    state_n = WAITP;
                end else if (op_q == OP_WRITE) begin
                    state_n = WRM;
                end else begin
                    state_n = WAITD;
                end
            end
            WAITP: begin
                if (wait_zero) begin
                    state_n = SETI;
                end
            end
            SETI: begin
                state_n = (op_q == OP_WRITE) ? WRM : WAITD;
            end
            WAITD: begin
                if (wait_zero) begin
                    state_n = LOADR;
                end
            end
            LOADR: begin
                state_n = (op_q == OP_RMW) ? WRM : IDLE;
            end
            WRM:     state_n = IDLE;
            NOP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Counter is armed on the edge entering a wait state so its first cycle already counts.
    assign wait_load = ((state_n == WAITP) || (state_n == WAITD)) && (state_n != state);
    assign wait_dec  = (state == WAITP) || (state == WAITD);

    lat_cnt #(
        .W(CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .dec      (wait_dec),
        .zero     (wait_zero)
    );

    always_comb begin
        busy = (state != IDLE);
        srcA = 1'b0;
        wAR  = 1'b0;
        wM   = 1'b0;
        wR   = 1'b0;
        done = 1'b0;
        case (state)
            SETA: wAR = 1'b1;
            SETI: begin
                wAR  = 1'b1;
                srcA = 1'b1;
            end
            LOADR: begin
                wR   = 1'b1;
                done = (op_q != OP_RMW);
            end
            WRM: begin
                wM   = 1'b1;
                done = 1'b1;
            end
            NOP:     done = 1'b1;
            default: ;
        endcase
    end

endmodule
